channel_profile_ctrl: RTL and testbench
=======================================

Name: channel_profile_ctrl

Overview:
- Configures and sequences the behavioural first-order IIR channel model, y[n] = b*u[n-1] + a*y[n-1], in the RX analog-model bench.
- Holds NUM_PROFILES coefficient profiles (b, a) written through a config handshake.
- On a select request, runs a flush/apply/settle sequence so the channel switches loss profile without a transient from stale state.
- Flags `settled` once the new response has had SETTLE_CYCLES to converge.

Parameters:
- NUM_PROFILES, 4, number of stored (b, a) profiles; must be >= 2.
- FLUSH_CYCLES, 2, cycles `flush` is held high to clear the channel's u[n-1]/y[n-1] state; must be >= 1.
- SETTLE_CYCLES, 256, cycles after apply before `settled` asserts; must be >= 1.
- DEFAULT_B, 0.005222, reset value of b in every profile.
- DEFAULT_A, 0.9948, reset value of a in every profile.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- cfg_valid  input  1  config write request
- cfg_ready  output  1  config write can be accepted
- cfg_idx  input  $clog2(NUM_PROFILES)  profile to write
- cfg_b  input  real  feed-forward coefficient
- cfg_a  input  real  feedback coefficient
- cfg_err  output  1  sticky: a config write was rejected
- sel_valid  input  1  profile switch request
- sel_ready  output  1  switch can be accepted
- sel_idx  input  $clog2(NUM_PROFILES)  profile to activate
- coef_b  output  real  b driven to the channel
- coef_a  output  real  a driven to the channel
- flush  output  1  clear channel internal state
- active_idx  output  $clog2(NUM_PROFILES)  profile currently applied
- settled  output  1  channel output valid for the active profile

Behaviour:
- Reset (asynchronous assert):
  - All profiles = (DEFAULT_B, DEFAULT_A); coef_b = DEFAULT_B, coef_a = DEFAULT_A.
  - active_idx = 0, flush = 0, settled = 0, cfg_err = 0.
  - State = SETTLE with counter = 0.
  - Reset mid-sequence aborts the sequence with no partial coefficient update.
- FSM states: IDLE, FLUSH, APPLY, SETTLE.
- Handshakes: a transfer occurs when valid and ready are both high at a clk edge. cfg_ready = sel_ready = (state == IDLE or SETTLE).
- Config write:
  - Stability check: |cfg_a| < 1.0 and cfg_b > 0.0.
  - Pass: the bank entry updates at that edge.
  - Fail: the entry is unchanged and cfg_err sets; it clears only on rst.
  - A write never changes coef_b/coef_a directly, including a write to active_idx; it takes effect only on the next select.
- Select accepted at edge T:
  - Next state FLUSH; settled = 0 and flush = 1 from T+1 for FLUSH_CYCLES cycles.
  - APPLY (1 cycle): flush = 0; bank[sel_idx] is read and registered onto coef_b/coef_a; active_idx = sel_idx. Outputs are visible at T+FLUSH_CYCLES+2.
  - SETTLE: counter counts 0..SETTLE_CYCLES-1. At terminal count settled = 1 and state goes to IDLE. settled stays 1 in IDLE.
- Simultaneous cfg and sel transfers in the same cycle: both are accepted. Because the bank is read in APPLY, a write to the selected index is the value that gets applied.
- Select during SETTLE: accepted; the settle is aborted and the sequence restarts at FLUSH.
- Select of the already-active index: the full sequence still runs (used to re-flush).
- Out-of-range index (NUM_PROFILES not a power of 2):
  - cfg: rejected and sets cfg_err.
  - sel: accepted with no effect, and state stays unchanged.
- Requests in FLUSH/APPLY: ready = 0; the requester must hold valid until ready.

Optional Feature:
- CHANNEL_DC_GAIN_CHECK_EN defined: the config check additionally requires DC gain g = cfg_b/(1.0-cfg_a) in [0.5, 2.0]. Writes outside that range are rejected and set cfg_err.
- CHANNEL_DC_GAIN_CHECK_EN undefined: only the stability check applies.
- Ports are identical in both builds.

Decomposition:
- Package channel_ctrl_pkg:
  - state enum (IDLE, FLUSH, APPLY, SETTLE);
  - constants DEFAULT_B_C = 0.005222, DEFAULT_A_C = 0.9948, A_MAX_C = 1.0, GAIN_MIN_C = 0.5, GAIN_MAX_C = 2.0;
  - struct coef_t {real b; real a;}.
- One sub-module, channel_profile_bank: NUM_PROFILES-entry coef_t register file with one write port (with enable) and one asynchronous read port. It holds the reset defaults.

Test Plan:
- Reset release, no stimulus -> coef = (0.005222, 0.9948), active_idx = 0, settled = 0 for 256 cycles, then 1; flush never asserts.
- Write idx1 = (0.01, 0.99), select idx1 at T -> flush high T+1..T+2; coef = (0.01, 0.99) and active_idx = 1 at T+4; settled = 1 at T+4+256.
- Write idx2 with a = 1.0, then a = -1.2 -> both rejected, cfg_err = 1, bank[2] still default. A later select of 2 applies (0.005222, 0.9948).
- cfg write idx3 = (0.02, 0.98) in the same cycle as sel idx3 -> applied coef = (0.02, 0.98).
- Select idx1, then select idx2 100 cycles into SETTLE -> settle restarts; settled stays 0 until 256 cycles after idx2's APPLY; final active_idx = 2.
- With CHANNEL_DC_GAIN_CHECK_EN: write (0.1, 0.5) (g = 0.2) -> rejected; write (0.01, 0.99) (g = 1.0) -> accepted. Without the macro, both are accepted.

Source files
------------

// File: rtl/channel_ctrl_pkg.sv
// channel_ctrl_pkg
// Shared types and constants for the channel profile controller.
//   state_t  : sequencer states (IDLE, FLUSH, APPLY, SETTLE)
//   coef_t   : one (b, a) coefficient pair of the first-order IIR channel
//   coef_stable_ok / dc_gain_in_range : config acceptance rules
// Optional build macro: CHANNEL_DC_GAIN_CHECK_EN adds the DC gain window
// to the config acceptance check (see coef_write_ok).
package channel_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        APPLY  = 2'd2,
        SETTLE = 2'd3
    } state_t;

    typedef struct {
        real b;
        real a;
    } coef_t;

    localparam real DEFAULT_B_C = 0.005222;
    localparam real DEFAULT_A_C = 0.9948;
    localparam real A_MAX_C     = 1.0;
    localparam real GAIN_MIN_C  = 0.5;
    localparam real GAIN_MAX_C  = 2.0;

    // Pole strictly inside the unit circle and a positive feed-forward term.
    function automatic logic coef_stable_ok(input real b, input real a);
        return (a < A_MAX_C) && (a > -A_MAX_C) && (b > 0.0);
    endfunction

    // Only meaningful once a < 1.0 has been established (denominator > 0).
    function automatic logic dc_gain_in_range(input real b, input real a);
        real g;
        g = b / (1.0 - a);
        return (g >= GAIN_MIN_C) && (g <= GAIN_MAX_C);
    endfunction

    function automatic logic coef_write_ok(input real b, input real a);
        logic ok;
        ok = coef_stable_ok(b, a);
`ifdef CHANNEL_DC_GAIN_CHECK_EN
        if (ok) begin
            ok = dc_gain_in_range(b, a);
        end
`endif
        return ok;
    endfunction

endpackage

// File: rtl/channel_profile_bank.sv
// channel_profile_bank
// NUM_PROFILES-entry (b, a) coefficient register file.
//   clk, rst          : clock, async active-high reset (all entries -> defaults)
//   wr_en, wr_idx     : write port enable and address
//   wr_b, wr_a        : write data
//   rd_idx            : asynchronous read address
//   rd_b, rd_a        : read data
// The b and a halves of each entry are held in parallel arrays indexed alike.
module channel_profile_bank
    import channel_ctrl_pkg::*;
#(
    parameter int  NUM_PROFILES = 4,
    parameter real DEFAULT_B    = DEFAULT_B_C,
    parameter real DEFAULT_A    = DEFAULT_A_C,
    localparam int IDX_W        = $clog2(NUM_PROFILES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  real              wr_b,
    input  real              wr_a,
    input  logic [IDX_W-1:0] rd_idx,
    output real              rd_b,
    output real              rd_a
);

    real bank_b [NUM_PROFILES];
    real bank_a [NUM_PROFILES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PROFILES; i++) begin
                bank_b[i] <= DEFAULT_B;
                bank_a[i] <= DEFAULT_A;
            end
        end else if (wr_en) begin
            bank_b[wr_idx] <= wr_b;
            bank_a[wr_idx] <= wr_a;
        end
    end

    assign rd_b = bank_b[rd_idx];
    assign rd_a = bank_a[rd_idx];

endmodule

// File: rtl/channel_profile_ctrl.sv
// channel_profile_ctrl
// Stores (b, a) profiles for the behavioural first-order IIR channel
// y[n] = b*u[n-1] + a*y[n-1] and switches between them with a
// flush / apply / settle sequence so no stale channel state leaks through.
//   clk, rst                  : clock, async active-high reset
//   cfg_valid/cfg_ready       : profile write handshake (cfg_idx, cfg_b, cfg_a)
//   cfg_err                   : sticky, set by any rejected write, cleared by rst
//   sel_valid/sel_ready       : profile switch handshake (sel_idx)
//   coef_b, coef_a            : coefficients driven to the channel
//   flush                     : clears channel u[n-1]/y[n-1] state
//   active_idx                : profile currently applied
//   settled                   : channel output valid for the active profile
// Optional build macro: CHANNEL_DC_GAIN_CHECK_EN (DC gain window on writes).
//
// state  | meaning
// IDLE   | settled, waiting for requests
// FLUSH  | flush held high for FLUSH_CYCLES cycles
// APPLY  | one cycle: selected bank entry registered onto coef_b/coef_a
// SETTLE | counting SETTLE_CYCLES before settled asserts
module channel_profile_ctrl
    import channel_ctrl_pkg::*;
#(
    parameter int  NUM_PROFILES  = 4,
    parameter int  FLUSH_CYCLES  = 2,
    parameter int  SETTLE_CYCLES = 256,
    parameter real DEFAULT_B     = DEFAULT_B_C,
    parameter real DEFAULT_A     = DEFAULT_A_C,
    localparam int IDX_W         = $clog2(NUM_PROFILES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [IDX_W-1:0] cfg_idx,
    input  real              cfg_b,
    input  real              cfg_a,
    output logic             cfg_err,
    input  logic             sel_valid,
    output logic             sel_ready,
    input  logic [IDX_W-1:0] sel_idx,
    output real              coef_b,
    output real              coef_a,
    output logic             flush,
    output logic [IDX_W-1:0] active_idx,
    output logic             settled
);

    localparam int CNT_MAX = (SETTLE_CYCLES > FLUSH_CYCLES) ? SETTLE_CYCLES : FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [IDX_W:0] NUM_PROF_W   = (IDX_W + 1)'(NUM_PROFILES);
    localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] pend_idx_q;

    logic             req_ready;
    logic             cfg_take;
    logic             cfg_ok;
    logic             sel_take;
    logic             apply_now;
    real              rd_b, rd_a;

    assign req_ready = (state_q == IDLE) || (state_q == SETTLE);
    assign cfg_ready = req_ready;
    assign sel_ready = req_ready;

    assign cfg_take = cfg_valid && req_ready;
    assign cfg_ok   = ({1'b0, cfg_idx} < NUM_PROF_W) && coef_write_ok(cfg_b, cfg_a);

    // An out-of-range select completes its handshake but is otherwise ignored.
    assign sel_take = sel_valid && req_ready && ({1'b0, sel_idx} < NUM_PROF_W);

    channel_profile_bank #(
        .NUM_PROFILES (NUM_PROFILES),
        .DEFAULT_B    (DEFAULT_B),
        .DEFAULT_A    (DEFAULT_A)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (cfg_take && cfg_ok),
        .wr_idx (cfg_idx),
        .wr_b   (cfg_b),
        .wr_a   (cfg_a),
        .rd_idx (pend_idx_q),
        .rd_b   (rd_b),
        .rd_a   (rd_a)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        apply_now = 1'b0;
        flush     = 1'b0;
        settled   = 1'b0;
        case (state_q)
            IDLE: begin
                settled = 1'b1;
                if (sel_take) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (cnt_q == FLUSH_LAST) begin
                    state_d = APPLY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            APPLY: begin
                apply_now = 1'b1;
                state_d   = SETTLE;
                cnt_d     = '0;
            end
            SETTLE: begin
                // A new select aborts the settle and restarts the sequence.
                if (sel_take) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Target index is captured at acceptance; the bank itself is read in
    // APPLY so a write accepted on the select edge is the one applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_idx_q <= '0;
        end else if (sel_take) begin
            pend_idx_q <= sel_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coef_b     <= DEFAULT_B;
            coef_a     <= DEFAULT_A;
            active_idx <= '0;
        end else if (apply_now) begin
            coef_b     <= rd_b;
            coef_a     <= rd_a;
            active_idx <= pend_idx_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else if (cfg_take && !cfg_ok) begin
            cfg_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_channel_profile_ctrl.sv
module tb_channel_profile_ctrl;

    localparam int  NP = 4;
    localparam int  FC = 2;
    localparam int  SC = 256;
    localparam real DB = 0.005222;
    localparam real DA = 0.9948;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       sel_valid = 1'b0;
    logic [1:0] cfg_idx = 2'd0;
    logic [1:0] sel_idx = 2'd0;
    real        cfg_b = 0.0;
    real        cfg_a = 0.0;
    logic       cfg_ready, sel_ready, cfg_err, flush, settled;
    logic [1:0] active_idx;
    real        coef_b, coef_a;

    int checks = 0;
    int failures = 0;

    // reference model
    real ref_b [NP];
    real ref_a [NP];
    bit  err_exp;
    int  q_idx [$];
    real q_b [$];
    real q_a [$];

    // monitor state
    int flush_len;
    bit flush_prev, settled_prev, apply_pend;
    int since;

    always #5 clk = ~clk;

    channel_profile_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_idx    (cfg_idx),
        .cfg_b      (cfg_b),
        .cfg_a      (cfg_a),
        .cfg_err    (cfg_err),
        .sel_valid  (sel_valid),
        .sel_ready  (sel_ready),
        .sel_idx    (sel_idx),
        .coef_b     (coef_b),
        .coef_a     (coef_a),
        .flush      (flush),
        .active_idx (active_idx),
        .settled    (settled)
    );

    task automatic chk(input bit ok, input string name, input string act, input string req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %s, expected %s (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit ref_accepts(input real b, input real a);
        bit  ok;
        real g;
        ok = (b > 0.0) && (a > -1.0) && (a < 1.0);
`ifdef CHANNEL_DC_GAIN_CHECK_EN
        if (ok) begin
            g  = b / (1.0 - a);
            ok = (g >= 0.5) && (g <= 2.0);
        end
`else
        g = 0.0;
`endif
        return ok;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            ref_b[i] = DB;
            ref_a[i] = DA;
        end
        err_exp = 1'b0;
        q_idx.delete();
        q_b.delete();
        q_a.delete();
    endtask

    // Monitor: every flush pulse is followed by an apply that must match the
    // oldest queued expectation; settled must rise exactly SC cycles later.
    always @(negedge clk) begin
        if (rst) begin
            flush_len    = 0;
            flush_prev   = 1'b0;
            settled_prev = 1'b0;
            apply_pend   = 1'b0;
            since        = 0;
        end else begin
            if (flush) begin
                flush_len++;
                chk(settled == 1'b0, "settled_in_flush", $sformatf("%0b", settled), "0");
            end
            if (flush_prev && !flush) begin
                chk(flush_len == FC, "flush_len", $sformatf("%0d", flush_len), $sformatf("%0d", FC));
                flush_len  = 0;
                apply_pend = 1'b1;
            end else if (apply_pend) begin
                apply_pend = 1'b0;
                since      = 0;
                if (q_idx.size() == 0) begin
                    chk(1'b0, "unexpected_apply", "apply", "none");
                end else begin
                    int  ei;
                    real eb, ea;
                    ei = q_idx.pop_front();
                    eb = q_b.pop_front();
                    ea = q_a.pop_front();
                    chk(int'(active_idx) == ei, "apply_idx", $sformatf("%0d", active_idx), $sformatf("%0d", ei));
                    chk(coef_b == eb, "apply_b", $sformatf("%f", coef_b), $sformatf("%f", eb));
                    chk(coef_a == ea, "apply_a", $sformatf("%f", coef_a), $sformatf("%f", ea));
                    chk(settled == 1'b0, "settled_at_apply", $sformatf("%0b", settled), "0");
                end
            end else begin
                since++;
            end
            if (!settled_prev && settled) begin
                chk(since == SC, "settle_time", $sformatf("%0d", since), $sformatf("%0d", SC));
            end
            flush_prev   = flush;
            settled_prev = settled;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        cfg_valid = 1'b0;
        sel_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        chk(coef_b == DB && coef_a == DA, "reset_coef", $sformatf("%f,%f", coef_b, coef_a), $sformatf("%f,%f", DB, DA));
        chk(active_idx == 2'd0, "reset_active", $sformatf("%0d", active_idx), "0");
        chk(flush == 1'b0 && settled == 1'b0 && cfg_err == 1'b0, "reset_flags",
            $sformatf("flush=%0b settled=%0b err=%0b", flush, settled, cfg_err), "all 0");
    endtask

    task automatic xfer(input bit cv, input int ci, input real cb, input real ca,
                        input bit sv, input int si);
        int n;
        n = 0;
        @(negedge clk);
        cfg_valid = cv;
        cfg_idx   = ci[1:0];
        cfg_b     = cb;
        cfg_a     = ca;
        sel_valid = sv;
        sel_idx   = si[1:0];
        while (!cfg_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            chk(1'b0, "ready_timeout", "ready=0", "ready=1");
            cfg_valid = 1'b0;
            sel_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (cv) begin
            if (ci < NP && ref_accepts(cb, ca)) begin
                ref_b[ci] = cb;
                ref_a[ci] = ca;
            end else begin
                err_exp = 1'b1;
            end
        end
        if (sv) begin
            q_idx.push_back(si);
            q_b.push_back(ref_b[si]);
            q_a.push_back(ref_a[si]);
        end
        #1;
        cfg_valid = 1'b0;
        sel_valid = 1'b0;
        if (cv) begin
            @(negedge clk);
            chk(cfg_err == err_exp, "cfg_err", $sformatf("%0b", cfg_err), $sformatf("%0b", err_exp));
        end
    endtask

    task automatic wait_settled();
        int n;
        n = 0;
        while (!settled && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(settled == 1'b1, "settle_wait", $sformatf("%0b", settled), "1");
    endtask

    initial begin
        model_reset();
        do_reset();

        // idle after reset: settles on defaults, no flush
        wait_settled();
        chk(active_idx == 2'd0, "idle_active", $sformatf("%0d", active_idx), "0");

        // plain write then switch
        xfer(1, 1, 0.01, 0.99, 0, 0);
        xfer(0, 0, 0.0, 0.0, 1, 1);
        wait_settled();

        // unstable writes rejected, entry keeps its default
        xfer(1, 2, 0.01, 1.0, 0, 0);
        xfer(1, 2, 0.01, -1.2, 0, 0);
        xfer(0, 0, 0.0, 0.0, 1, 2);
        wait_settled();

        // write and select of the same index on the same edge
        xfer(1, 3, 0.02, 0.98, 1, 3);
        wait_settled();

        // select during settle restarts the sequence
        xfer(0, 0, 0.0, 0.0, 1, 1);
        repeat (103) @(negedge clk);
        chk(settled == 1'b0, "mid_settle", $sformatf("%0b", settled), "0");
        xfer(0, 0, 0.0, 0.0, 1, 2);
        wait_settled();
        chk(active_idx == 2'd2, "restart_active", $sformatf("%0d", active_idx), "2");

        // DC gain window (effect depends on build)
        xfer(1, 0, 0.1, 0.5, 0, 0);
        xfer(1, 0, 0.01, 0.99, 0, 0);
        xfer(0, 0, 0.0, 0.0, 1, 0);
        wait_settled();

        // reselect of the active index still runs the full sequence
        xfer(0, 0, 0.0, 0.0, 1, 0);
        wait_settled();

        // reset in the middle of a flush
        xfer(0, 0, 0.0, 0.0, 1, 1);
        @(negedge clk);
        do_reset();
        wait_settled();

        // randomized traffic
        for (int i = 0; i < 25; i++) begin
            int  op, ci, si;
            real b, a;
            op = int'($urandom_range(0, 2));
            ci = int'($urandom_range(0, NP - 1));
            si = int'($urandom_range(0, NP - 1));
            b  = real'($urandom_range(0, 600)) / 10000.0 - 0.01;
            a  = real'($urandom_range(0, 2400)) / 1000.0 - 1.2;
            xfer(op != 1, ci, b, a, op != 0, si);
            repeat ($urandom_range(0, 300)) @(negedge clk);
        end
        wait_settled();
        chk(q_idx.size() == 0, "queue_drained", $sformatf("%0d", q_idx.size()), "0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
